// File: rtl/time_pkg.sv
// ---------------------------------------------------------------------------
// time_pkg
// Shared definitions for the time-set controller:
//   - state_t       : controller FSM states
//   - FIELD_*       : edit_field encoding presented to the display
//   - HOUR_MAX,
//     MINSEC_MAX    : largest legal packed-BCD value of each field
//   - *_MSB / *_LSB : slice positions of each field in the 20-bit time word
//                     (hh_hhhh : mmm_mmmm : sss_ssss)
//   - field_of_state: maps an FSM state to its edit_field code
// ---------------------------------------------------------------------------
package time_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EDIT_H,
    ST_EDIT_M,
    ST_EDIT_S,
    ST_COMMIT
  } state_t;

  localparam logic [1:0] FIELD_NONE    = 2'd0;
  localparam logic [1:0] FIELD_HOURS   = 2'd1;
  localparam logic [1:0] FIELD_MINUTES = 2'd2;
  localparam logic [1:0] FIELD_SECONDS = 2'd3;

  localparam logic [5:0] HOUR_MAX   = 6'h23;
  localparam logic [6:0] MINSEC_MAX = 7'h59;

  localparam int HOUR_MSB = 19;
  localparam int HOUR_LSB = 14;
  localparam int MIN_MSB  = 13;
  localparam int MIN_LSB  = 7;
  localparam int SEC_MSB  = 6;
  localparam int SEC_LSB  = 0;

  function automatic logic [1:0] field_of_state(input state_t st);
    case (st)
      ST_EDIT_H: return FIELD_HOURS;
      ST_EDIT_M: return FIELD_MINUTES;
      ST_EDIT_S: return FIELD_SECONDS;
      default:   return FIELD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd_field_step.sv
// ---------------------------------------------------------------------------
// bcd_field_step
// Combinational packed-BCD step for one time field (tens digit in the upper
// W-4 bits, units digit in the low nibble).
// Ports:
//   value      in  W  current field value
//   max_val    in  W  largest legal value (wrap point)
//   inc        in  1  step up by one (wraps max_val -> 0)
//   dec        in  1  step down by one (wraps 0 -> max_val)
//   check_en   in  1  enables the range check; when low, valid is forced high
//   next_value out W  stepped value (unchanged when inc == dec)
//   valid      out 1  value is valid BCD and within 0..max_val
// ---------------------------------------------------------------------------
module bcd_field_step #(
  parameter int W = 7
) (
  input  logic [W-1:0] value,
  input  logic [W-1:0] max_val,
  input  logic         inc,
  input  logic         dec,
  input  logic         check_en,
  output logic [W-1:0] next_value,
  output logic         valid
);

  logic [W-5:0] tens;
  logic [3:0]   units;

  assign tens  = value[W-1:4];
  assign units = value[3:0];

  // For legal BCD digits the binary order matches the decimal order, so a
  // plain magnitude compare against max_val is a valid range check.
  always_comb begin
    valid = 1'b1;
    if (check_en) begin
      valid = (units <= 4'd9) && (value <= max_val);
    end
  end

  // Carry/borrow between the digits keeps every digit within 0..9.
  always_comb begin
    next_value = value;
    if (inc && !dec) begin
      if (value == max_val) begin
        next_value = '0;
      end else if (units == 4'd9) begin
        next_value = {tens + 1'b1, 4'd0};
      end else begin
        next_value = {tens, units + 4'd1};
      end
    end else if (dec && !inc) begin
      if (value == '0) begin
        next_value = max_val;
      end else if (units == 4'd0) begin
        next_value = {tens - 1'b1, 4'd9};
      end else begin
        next_value = {tens, units - 4'd1};
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Button-driven editor for the packed-BCD time of the 1 Hz clock counter.
// Captures the live time, lets the user step hours/minutes/seconds and then
// commits the result with an active-low overwrite pulse of OW_CYCLES clocks.
// Optional build macro: TIME_SET_AUTO_REPEAT_EN (held inc/dec auto-repeat
// after REPEAT_DLY cycles, then every REPEAT_PER cycles).
// Ports:
//   clk         in   1  system clock
//   rst_n       in   1  asynchronous active-low reset
//   btn_mode    in   1  advance edit field (level, synchronised)
//   btn_inc     in   1  increment selected field (level)
//   btn_dec     in   1  decrement selected field (level)
//   btn_cancel  in   1  abandon the edit (level)
//   time_cur    in  20  live time from the counter
//   time_in     out 20  time to load into the counter
//   time_ow     out  1  active-low overwrite strobe
//   edit_field  out  2  0 none, 1 hours, 2 minutes, 3 seconds
//   edit_time   out 20  current edit value for display
//   busy        out  1  controller is not idle
// ---------------------------------------------------------------------------
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int OW_CYCLES  = 4,
  parameter int REPEAT_DLY = 500,
  parameter int REPEAT_PER = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  input  logic        btn_cancel,
  input  logic [19:0] time_cur,
  output logic [19:0] time_in,
  output logic        time_ow,
  output logic [1:0]  edit_field,
  output logic [19:0] edit_time,
  output logic        busy
);

  localparam int OW_W = (OW_CYCLES > 1) ? $clog2(OW_CYCLES) : 1;

  state_t      state_q, state_d;
  logic [19:0] edit_q, edit_d;
  logic [19:0] time_in_q, time_in_d;
  logic        time_ow_q, time_ow_d;
  logic [OW_W-1:0] ow_cnt_q, ow_cnt_d;

  logic mode_q, inc_q, dec_q, cancel_q;
  logic mode_press, inc_press, dec_press, cancel_press;
  logic in_edit;
  logic inc_ev, dec_ev, step_inc, step_dec;

  logic [5:0] h_val, h_next;
  logic [6:0] m_val, m_next, s_val, s_next;
  logic       h_valid, m_valid, s_valid;

  assign mode_press   = btn_mode   & ~mode_q;
  assign inc_press    = btn_inc    & ~inc_q;
  assign dec_press    = btn_dec    & ~dec_q;
  assign cancel_press = btn_cancel & ~cancel_q;

  assign in_edit = (state_q == ST_EDIT_H) || (state_q == ST_EDIT_M) ||
                   (state_q == ST_EDIT_S);

`ifdef TIME_SET_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             rpt_q, rpt_d;
  logic             rpt_step;
  logic             hold_one;

  assign hold_one = in_edit && (btn_inc ^ btn_dec);

  // Hold counter: starts at 1 on the press edge, fires the first repeat at
  // REPEAT_DLY, then re-arms every REPEAT_PER. Anything that ends a clean
  // single-button hold (release, other button, mode, cancel) clears it.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    rpt_d      = rpt_q;
    rpt_step   = 1'b0;
    if (!hold_one || mode_press || cancel_press) begin
      hold_cnt_d = '0;
      rpt_d      = 1'b0;
    end else if (inc_press || dec_press) begin
      hold_cnt_d = RPT_W'(1);
      rpt_d      = 1'b0;
    end else if (hold_cnt_q != '0) begin
      if (!rpt_q && (hold_cnt_q == RPT_W'(REPEAT_DLY))) begin
        rpt_step   = 1'b1;
        rpt_d      = 1'b1;
        hold_cnt_d = RPT_W'(1);
      end else if (rpt_q && (hold_cnt_q == RPT_W'(REPEAT_PER))) begin
        rpt_step   = 1'b1;
        hold_cnt_d = RPT_W'(1);
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      rpt_q      <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      rpt_q      <= rpt_d;
    end
  end

  assign inc_ev = inc_press | (rpt_step & btn_inc);
  assign dec_ev = dec_press | (rpt_step & btn_dec);
`else
  logic [31:0] unused_repeat_cfg;
  assign unused_repeat_cfg = REPEAT_DLY ^ REPEAT_PER;

  assign inc_ev = inc_press;
  assign dec_ev = dec_press;
`endif

  // Simultaneous inc and dec cancel each other.
  assign step_inc = inc_ev & ~dec_ev;
  assign step_dec = dec_ev & ~inc_ev;

  // In IDLE the steppers look at the live time so their valid flags drive
  // capture sanitising; in the edit states they step the edit register.
  always_comb begin
    h_val = edit_q[HOUR_MSB:HOUR_LSB];
    m_val = edit_q[MIN_MSB:MIN_LSB];
    s_val = edit_q[SEC_MSB:SEC_LSB];
    if (state_q == ST_IDLE) begin
      h_val = time_cur[HOUR_MSB:HOUR_LSB];
      m_val = time_cur[MIN_MSB:MIN_LSB];
      s_val = time_cur[SEC_MSB:SEC_LSB];
    end
  end

  bcd_field_step #(.W(6)) u_hours (
    .value      (h_val),
    .max_val    (HOUR_MAX),
    .inc        (step_inc && (state_q == ST_EDIT_H)),
    .dec        (step_dec && (state_q == ST_EDIT_H)),
    .check_en   (1'b1),
    .next_value (h_next),
    .valid      (h_valid)
  );

  bcd_field_step #(.W(7)) u_minutes (
    .value      (m_val),
    .max_val    (MINSEC_MAX),
    .inc        (step_inc && (state_q == ST_EDIT_M)),
    .dec        (step_dec && (state_q == ST_EDIT_M)),
    .check_en   (1'b1),
    .next_value (m_next),
    .valid      (m_valid)
  );

  bcd_field_step #(.W(7)) u_seconds (
    .value      (s_val),
    .max_val    (MINSEC_MAX),
    .inc        (step_inc && (state_q == ST_EDIT_S)),
    .dec        (step_dec && (state_q == ST_EDIT_S)),
    .check_en   (1'b1),
    .next_value (s_next),
    .valid      (s_valid)
  );

  // Next-state logic. Priority inside the edit states: cancel, then mode,
  // then inc/dec. COMMIT ignores every button and only times the pulse.
  always_comb begin
    state_d   = state_q;
    edit_d    = edit_q;
    time_in_d = time_in_q;
    time_ow_d = time_ow_q;
    ow_cnt_d  = ow_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (mode_press) begin
          edit_d  = {h_valid ? h_val : 6'h00,
                     m_valid ? m_val : 7'h00,
                     s_valid ? s_val : 7'h00};
          state_d = ST_EDIT_H;
        end
      end
      ST_EDIT_H, ST_EDIT_M, ST_EDIT_S: begin
        if (cancel_press) begin
          state_d = ST_IDLE;
        end else if (mode_press) begin
          if (state_q == ST_EDIT_H) begin
            state_d = ST_EDIT_M;
          end else if (state_q == ST_EDIT_M) begin
            state_d = ST_EDIT_S;
          end else begin
            state_d   = ST_COMMIT;
            time_in_d = edit_q;
            time_ow_d = 1'b0;
            ow_cnt_d  = OW_W'(OW_CYCLES - 1);
          end
        end else begin
          edit_d = {h_next, m_next, s_next};
        end
      end
      ST_COMMIT: begin
        if (ow_cnt_q == '0) begin
          time_ow_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          ow_cnt_d = ow_cnt_q - 1'b1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        time_ow_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      edit_q    <= '0;
      time_in_q <= '0;
      time_ow_q <= 1'b1;
      ow_cnt_q  <= '0;
      mode_q    <= 1'b0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      cancel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      edit_q    <= edit_d;
      time_in_q <= time_in_d;
      time_ow_q <= time_ow_d;
      ow_cnt_q  <= ow_cnt_d;
      mode_q    <= btn_mode;
      inc_q     <= btn_inc;
      dec_q     <= btn_dec;
      cancel_q  <= btn_cancel;
    end
  end

  assign time_in    = time_in_q;
  assign time_ow    = time_ow_q;
  assign edit_time  = edit_q;
  assign edit_field = field_of_state(state_q);
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Writer side of the packed-BCD time-load interface used by the 1 Hz BCD clock counter. Produces `time_in[19:0]` and the active-low overwrite strobe `time_ow` that the counter consumes.
- Lets a user edit hours, minutes and seconds with mode/inc/dec buttons. Editing starts from the counter's live `time_out`. The result is committed with a clean overwrite pulse.
- Runs on the system clock. Sits between the button synchronisers and the clock counter.

Parameters:
- OW_CYCLES, 4: number of clk cycles `time_ow` is held low per commit (minimum 1).
- REPEAT_DLY, 500: hold cycles before auto-repeat starts (used only with AUTO_REPEAT_EN).
- REPEAT_PER, 100: cycles between auto-repeat steps (used only with AUTO_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_mode  in  1  level; already synchronised and debounced; advances the edit field.
- btn_inc  in  1  level; increments the selected field.
- btn_dec  in  1  level; decrements the selected field.
- btn_cancel  in  1  level; abandons the edit without committing.
- time_cur  in  20  live time, format hh_hhhh:mmm_mmmm:sss_ssss in BCD.
- time_in  out  20  time to load, same format.
- time_ow  out  1  active-low overwrite strobe to the counter.
- edit_field  out  2  0 = none, 1 = hours, 2 = minutes, 3 = seconds.
- edit_time  out  20  current edit value, for display.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - `time_ow` = 1.
  - `time_in`, `edit_time` = 0.
  - `edit_field` = 0, `busy` = 0.
  - state = IDLE.
  - Edge-detect registers = 0.
- Buttons are rising-edge detected with one register each. A press acts on the clk edge after the input rises. Holding a button gives one action (unless AUTO_REPEAT_EN).
- FSM states: IDLE, EDIT_H, EDIT_M, EDIT_S, COMMIT.
  - IDLE + mode press: capture `time_cur` into the edit register, go to EDIT_H.
  - EDIT_H + mode press: go to EDIT_M.
  - EDIT_M + mode press: go to EDIT_S.
  - EDIT_S + mode press: go to COMMIT.
  - Cancel in any EDIT state: go to IDLE. `time_in` is unchanged and no pulse is issued.
- Capture sanitising: any field that is not valid BCD, or is out of range, is captured as 00. Ranges: hours 00–23, minutes and seconds 00–59.
- Inc/dec act on the selected field only.
  - BCD arithmetic with wrap-around.
  - Hours: 23 inc → 00; 00 dec → 23.
  - Minutes and seconds: 59 inc → 00; 00 dec → 59.
  - Digit carry/borrow: 09 inc → 10; 10 dec → 09.
  - A field never holds a non-BCD digit.
- Simultaneous events on the same cycle:
  - cancel beats mode, mode beats inc/dec.
  - inc and dec together produce no change.
- COMMIT entry edge:
  - `time_in` ← edit register and `time_ow` ← 0 on the same edge.
  - `time_ow` stays low for exactly OW_CYCLES cycles, then returns to 1.
  - State returns to IDLE on the same edge that `time_ow` rises.
  - `time_in` stays stable from COMMIT entry until the next COMMIT.
- In COMMIT, all buttons are ignored, including cancel.
- `edit_time` follows the edit register and holds it after IDLE is reached.
- `edit_field` encodes the state; it is 0 in IDLE and COMMIT. `busy` = (state != IDLE).
- Reset mid-edit or mid-commit: all outputs return to their reset values immediately. `time_ow` goes high asynchronously, so the pulse is truncated.

Optional Feature:
- Macro: TIME_SET_AUTO_REPEAT_EN.
- Defined: while inc (or dec) is held alone in an EDIT state:
  - first step on the press edge;
  - next step after REPEAT_DLY cycles;
  - then one step every REPEAT_PER cycles.
  - Release, or pressing the other button, stops repeat and clears the hold counter.
- Undefined: one step per press only. The hold counter and the REPEAT_* parameters are unused and no counter logic is generated.

Decomposition:
- Shared package `time_pkg`:
  - state enum;
  - field-select encoding;
  - BCD limit constants HOUR_MAX = 6'h23, MINSEC_MAX = 7'h59;
  - field slice positions within the 20-bit time word.
- Sub-module `bcd_field_step`, combinational:
  - inputs: value, max, inc, dec, valid-check;
  - outputs: next value and a range-valid flag.
  - Instantiated once per field, with width parameterised (6 or 7 bits).

Test Plan:
- Edit hours: `time_cur` = 12:34:56; press mode, inc ×12, mode, mode, mode → `time_in` = 00:34:56 (12 + 12 wraps 23 → 00); `time_ow` low exactly 4 cycles; `busy` falls as `time_ow` rises.
- Seconds wrap and carry: edit seconds from 00, dec ×1 → 59; inc ×1 → 00. Then edit minutes from 09, inc → 10; dec → 09.
- Sanitising: `time_cur` = 2A:7F:59 → captured `edit_time` = 00:00:59.
- Same-cycle events:
  - mode+inc together in EDIT_H → moves to EDIT_M, hours unchanged;
  - inc+dec together → no change;
  - cancel+mode in EDIT_S → IDLE, `time_ow` never low.
- Reset mid-commit: assert `rst_n` low during the 2nd low cycle of `time_ow` → `time_ow` = 1 asynchronously, `time_in` = 0, state IDLE.
- TIME_SET_AUTO_REPEAT_EN with REPEAT_DLY = 5, REPEAT_PER = 2: hold inc 12 cycles on minutes = 00 → values 01 (press), 02 (cycle 5), 03 (cycle 7), 04 (cycle 9), 05 (cycle 11).
